// File: rtl/multi_pattern_comparator_pkg.sv
// Shared types and elaboration helpers for the multi-pattern byte-stream comparator.
package mpc_pkg;

    typedef logic [7:0] byte_t;

    // An index width that stays legal (>= 1 bit) even for a single channel.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bytes visible to the comparators: retained history plus the current word.
    function automatic int win_len(input int pat_bytes, input int data_bytes);
        return pat_bytes - 1 + data_bytes;
    endfunction

endpackage

// File: rtl/multi_pattern_comparator_if.sv
// Stream, pattern-programming and match-report bundle for multi_pattern_comparator.
// match_offset exists only when MATCH_OFFSET_EN is defined.
interface multi_pattern_comparator_if
    import mpc_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int PAT_BYTES  = 6,
    parameter int NUM_PAT    = 4,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = idx_w(NUM_PAT);

    logic                            clear;
    logic                            pat_load;
    logic [NUM_PAT*PAT_BYTES*8-1:0]  pattern_in;
    logic [NUM_PAT-1:0]              pat_en;
    logic [DATA_BYTES*8-1:0]         data_in;
    logic                            data_valid;
    logic [DATA_BYTES*8-1:0]         data_out;
    logic                            data_out_valid;
    logic [NUM_PAT-1:0]              match;
    logic                            match_any;
    logic [IDX_W-1:0]                match_first;
`ifdef MATCH_OFFSET_EN
    logic [CNT_W-1:0]                match_offset;
`endif

    modport master (
        output clear, pat_load, pattern_in, pat_en, data_in, data_valid,
        input  data_out, data_out_valid, match, match_any, match_first
`ifdef MATCH_OFFSET_EN
        , input match_offset
`endif
    );

    modport slave (
        input  clear, pat_load, pattern_in, pat_en, data_in, data_valid,
        output data_out, data_out_valid, match, match_any, match_first
`ifdef MATCH_OFFSET_EN
        , output match_offset
`endif
    );

endinterface

// File: rtl/mpc_window_cmp.sv
// Compares one pattern against every byte alignment of the window (byte 0 = oldest, in MSBs).
// A candidate only counts once enough real bytes have been seen to fill it.
module mpc_window_cmp
    import mpc_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int PAT_BYTES  = 6,
    parameter int CNT_W      = 16
) (
    input  logic [win_len(PAT_BYTES, DATA_BYTES)*8-1:0] window,
    input  logic [PAT_BYTES*8-1:0]                      pattern,
    input  logic [CNT_W-1:0]                            seen,
    output logic [DATA_BYTES-1:0]                       hit
);
    localparam int WIN_LEN = win_len(PAT_BYTES, DATA_BYTES);
    localparam int SW      = CNT_W + 32;

    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_cand
            logic [PAT_BYTES-1:0] byte_eq;
            logic                 valid;

            for (genvar gj = 0; gj < PAT_BYTES; gj++) begin : g_byte
                byte_t win_byte;
                byte_t pat_byte;
                assign win_byte    = window[(WIN_LEN-gi-gj)*8-1 -: 8];
                assign pat_byte    = pattern[(PAT_BYTES-gj)*8-1 -: 8];
                assign byte_eq[gj] = (win_byte == pat_byte);
            end

            // A saturated counter means the history is certainly full.
            assign valid   = (&seen) ||
                             ((SW'(seen) + SW'(gi) + SW'(1)) >= SW'(PAT_BYTES));
            assign hit[gi] = valid && (&byte_eq);
        end
    endgenerate

endmodule

// File: rtl/multi_pattern_comparator.sv
// Byte-aligned multi-pattern stream comparator with one-cycle pass-through latency.
// Optional MATCH_OFFSET_EN adds the stream byte offset of the first match.
module multi_pattern_comparator
    import mpc_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int PAT_BYTES  = 6,
    parameter int NUM_PAT    = 4,
    parameter int CNT_W      = 16
) (
    input logic                        clk,
    input logic                        n_rst,
    multi_pattern_comparator_if.slave  bus
);
    localparam int HIST    = PAT_BYTES - 1;
    localparam int HIST_W  = ((HIST > 0) ? HIST : 1) * 8;
    localparam int WIN_LEN = win_len(PAT_BYTES, DATA_BYTES);
    localparam int IDX_W   = idx_w(NUM_PAT);
    localparam int DW      = DATA_BYTES * 8;
    localparam int PW      = PAT_BYTES * 8;

    logic [PW-1:0]         pat_reg [NUM_PAT];
    logic [NUM_PAT-1:0]    pat_en_reg;
    logic [NUM_PAT-1:0]    match_reg;
    logic [NUM_PAT-1:0]    match_cur;
    logic [NUM_PAT-1:0]    new_hits;
    logic [HIST_W-1:0]     hist_reg;
    logic [HIST_W-1:0]     hist_cur;
    logic [WIN_LEN*8-1:0]  window;
    logic [CNT_W-1:0]      seen_reg;
    logic [CNT_W-1:0]      seen_cur;
    logic [CNT_W-1:0]      seen_next;
    logic [CNT_W:0]        seen_sum;
    logic [IDX_W-1:0]      first_reg;
    logic [IDX_W-1:0]      first_next;
    logic [DW-1:0]         data_out_reg;
    logic                  data_out_valid_reg;
    logic [DATA_BYTES-1:0] hit_vec [NUM_PAT];
`ifdef MATCH_OFFSET_EN
    logic [CNT_W-1:0]      offset_reg;
    logic [CNT_W-1:0]      offset_next;
`endif

    // A clear in the same cycle as a beat makes that beat the first of a fresh frame.
    assign hist_cur  = bus.clear ? '0 : hist_reg;
    assign seen_cur  = bus.clear ? '0 : seen_reg;
    assign match_cur = bus.clear ? '0 : match_reg;

    generate
        if (HIST > 0) begin : g_hist
            assign window = {hist_cur[HIST*8-1:0], bus.data_in};
        end else begin : g_nohist
            assign window = bus.data_in;
        end

        for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_chan
            mpc_window_cmp #(
                .DATA_BYTES (DATA_BYTES),
                .PAT_BYTES  (PAT_BYTES),
                .CNT_W      (CNT_W)
            ) u_cmp (
                .window  (window),
                .pattern (pat_reg[gi]),
                .seen    (seen_cur),
                .hit     (hit_vec[gi])
            );
            assign new_hits[gi] = bus.data_valid && pat_en_reg[gi] && (|hit_vec[gi]);
        end
    endgenerate

    assign seen_sum  = {1'b0, seen_cur} + (CNT_W+1)'(DATA_BYTES);
    assign seen_next = seen_sum[CNT_W] ? '1 : seen_sum[CNT_W-1:0];

    // Descending scans so the lowest channel, then its lowest alignment, wins.
    always_comb begin
        first_next = '0;
`ifdef MATCH_OFFSET_EN
        offset_next = '0;
`endif
        for (int i = NUM_PAT-1; i >= 0; i--) begin
            if (new_hits[i]) begin
                first_next = IDX_W'(i);
`ifdef MATCH_OFFSET_EN
                for (int k = DATA_BYTES-1; k >= 0; k--) begin
                    if (hit_vec[i][k]) begin
                        offset_next = seen_cur + CNT_W'(k) - CNT_W'(HIST);
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_PAT; i++) pat_reg[i] <= '0;
            pat_en_reg         <= '0;
            hist_reg           <= '0;
            seen_reg           <= '0;
            match_reg          <= '0;
            first_reg          <= '0;
            data_out_reg       <= '0;
            data_out_valid_reg <= 1'b0;
`ifdef MATCH_OFFSET_EN
            offset_reg         <= '0;
`endif
        end else begin
            data_out_valid_reg <= bus.data_valid;
            if (bus.data_valid) data_out_reg <= bus.data_in;

            // pat_load wins: a concurrent beat's hits are discarded with the old state.
            if (bus.pat_load) begin
                for (int i = 0; i < NUM_PAT; i++) pat_reg[i] <= bus.pattern_in[i*PW +: PW];
                pat_en_reg <= bus.pat_en;
                hist_reg   <= '0;
                seen_reg   <= '0;
                match_reg  <= '0;
                first_reg  <= '0;
`ifdef MATCH_OFFSET_EN
                offset_reg <= '0;
`endif
            end else if (bus.data_valid) begin
                hist_reg  <= window[HIST_W-1:0];
                seen_reg  <= seen_next;
                match_reg <= match_cur | new_hits;
                if ((match_cur == '0) && (new_hits != '0)) begin
                    first_reg  <= first_next;
`ifdef MATCH_OFFSET_EN
                    offset_reg <= offset_next;
`endif
                end else if (bus.clear) begin
                    first_reg  <= '0;
`ifdef MATCH_OFFSET_EN
                    offset_reg <= '0;
`endif
                end
            end else if (bus.clear) begin
                hist_reg   <= '0;
                seen_reg   <= '0;
                match_reg  <= '0;
                first_reg  <= '0;
`ifdef MATCH_OFFSET_EN
                offset_reg <= '0;
`endif
            end
        end
    end

    assign bus.data_out       = data_out_reg;
    assign bus.data_out_valid = data_out_valid_reg;
    assign bus.match          = match_reg;
    assign bus.match_any      = |match_reg;
    assign bus.match_first    = first_reg;
`ifdef MATCH_OFFSET_EN
    assign bus.match_offset   = offset_reg;
`endif

endmodule
